rx_burst_interface: RTL and testbench
=====================================

RX_BURST_INTERFACE -- requirements
Module: rx_burst_interface

Interface
REQ-001 Parameter BURST_MAX, default 32, maximum number of data words allowed between two burst/idle control words.
REQ-002 Parameter NUM_CHANNELS, default 256, number of legal channel IDs (1..256).
REQ-003 USER_CLK  in  1  the single clock; every register updates on its rising edge.
REQ-004 SYSTEM_RESET  in  1  synchronous, active-high reset.
REQ-005 DATA_IN  in  64  descrambled 64-bit word payload.
REQ-006 HEADER_IN  in  2  sync header: 01 = data word, 10 = control word, 00/11 = invalid.
REQ-007 DATA_IN_VALID  in  1  DATA_IN/HEADER_IN are valid this cycle.
REQ-008 DATA_OUT  out  64  forwarded data word; all-zero when DATA_OUT_VALID=0.
REQ-009 DATA_OUT_VALID  out  1  DATA_OUT and its tags are valid; single-cycle qualifier.
REQ-010 DATA_OUT_SOP  out  1  first word of a packet.
REQ-011 DATA_OUT_EOP  out  1  last word of a packet.
REQ-012 DATA_OUT_EOP_BYTES  out  3  valid bytes in an EOP word; 000 = 8 bytes; 0 on non-EOP words.
REQ-013 DATA_OUT_CHANNEL  out  8  channel of the packet the word belongs to.
REQ-014 DATA_OUT_ERR  out  1  the packet is errored (on the word where it is known).
REQ-015 FLOW_CTRL_OUT  out  16  in-band flow-control field of the latest burst/idle control word.
REQ-016 FLOW_CTRL_RESET_CAL  out  1  reset-calendar bit of that word.
REQ-017 FLOW_CTRL_VALID  out  1  one-cycle pulse when FLOW_CTRL_OUT/FLOW_CTRL_RESET_CAL update.
REQ-018 PROTOCOL_ERR  out  1  one-cycle pulse per detected protocol violation.

Function
REQ-019 Burst/idle control word = valid, HEADER_IN=10, DATA_IN[63:62]=11; fields: SOP=[61], EOP_FMT=[60:57], RESET_CAL=[56], FC=[55:40], CHANNEL=[39:32].
REQ-020 Valid words with HEADER_IN=10 and DATA_IN[63:62]!=11 (framing words) shall be ignored, with no effect on state, hold register, counters or outputs.
REQ-021 Valid words with HEADER_IN 00 or 11 shall pulse PROTOCOL_ERR and otherwise be ignored.
REQ-022 States: IDLE (no packet open) and PKT (packet open); a one-word hold register (word, SOP tag, channel, err, full flag) delays each data word until the next data or burst control word decides its EOP status.
REQ-023 Data word in PKT: if hold is full, emit the held word with EOP=0; then load the new word into hold, tagged SOP=sop_pending, and clear sop_pending.
REQ-024 Data word in IDLE: discarded; pulse PROTOCOL_ERR.
REQ-025 Every burst control word shall update FLOW_CTRL_OUT/FLOW_CTRL_RESET_CAL and pulse FLOW_CTRL_VALID in the following cycle.
REQ-026 Burst control word, EOP processing first: EOP_FMT=1xxx -> emit held word with EOP=1, EOP_BYTES=xxx; EOP_FMT=0001 -> emit with EOP=1, ERR=1, EOP_BYTES=000; both -> go IDLE, hold empty.
REQ-027 EOP_FMT=0000 with hold full -> emit held word with EOP=0, state unchanged.
REQ-028 EOP indicated with hold empty or in IDLE -> PROTOCOL_ERR pulse, no output, state -> IDLE.
REQ-029 Other EOP_FMT encodings (0010-0111) -> PROTOCOL_ERR pulse, treated as EOP with ERR=1.
REQ-030 SOP processing after EOP in the same word: SOP=1 in IDLE -> PKT, sop_pending=1, channel latched.
REQ-031 SOP=1 while still in PKT -> PROTOCOL_ERR; any held word is emitted with EOP=1, ERR=1; new packet opens as per REQ-030.
REQ-032 Latched CHANNEL >= NUM_CHANNELS -> PROTOCOL_ERR at the SOP; every word of that packet carries DATA_OUT_ERR=1.
REQ-033 Burst counter: cleared by each burst control word, incremented per accepted data word, saturating; the data word that makes the count exceed BURST_MAX pulses PROTOCOL_ERR once per burst and is still forwarded.
REQ-034 Output latency: an emitted word appears on DATA_OUT exactly one cycle after the cycle of the word that triggered its emission; at most one word emitted per cycle.
REQ-035 Multiple violations in one cycle produce a single PROTOCOL_ERR pulse.
REQ-036 DATA_IN_VALID=0 cycles change nothing; outputs other than FLOW_CTRL_OUT/FLOW_CTRL_RESET_CAL return to 0.

Reset
REQ-037 SYSTEM_RESET=1 shall clear all outputs to 0, state to IDLE, hold empty, sop_pending=0, burst counter=0 in the next cycle.
REQ-038 Reset mid-packet discards the held word without emitting it; it dominates all inputs in the same cycle.

Verification
REQ-039 Ctrl(SOP=1,CH=5), data A, data B, ctrl(EOP_FMT=1011) -> A (SOP=1,CH=5), then B (EOP=1,EOP_BYTES=011), each one cycle after the triggering word.
REQ-040 Ctrl(EOP=1000,SOP=1,CH=7) closing packet X and opening Y, data C -> X last word EOP=1,EOP_BYTES=000; C held with SOP=1,CH=7; no PROTOCOL_ERR.
REQ-041 Data word in IDLE; ctrl EOP in IDLE; header 11 -> three PROTOCOL_ERR pulses, DATA_OUT_VALID stays 0.
REQ-042 BURST_MAX=4: SOP then 5 data words with no control word -> PROTOCOL_ERR on the 5th word only; all words forwarded.
REQ-043 Ctrl(EOP_FMT=0001) -> held word EOP=1, ERR=1; ctrl FC=16'hA5A5 -> FLOW_CTRL_OUT=A5A5, FLOW_CTRL_VALID one cycle.
REQ-044 SYSTEM_RESET pulsed with hold full in PKT -> no emission, all outputs 0; next data word -> PROTOCOL_ERR (IDLE).

Source files
------------

// File: rtl/rx_burst_interface.sv
// Purpose : Receive-side burst framer. It splits a descrambled 64b word stream, delimited by
//           burst/idle control words, into packets tagged with SOP/EOP/channel/error.
// Latency : 1 cycle from the deciding input word to DATA_OUT; flow control 1 cycle after its control word.
// Backpress: none. The input is qualified only by DATA_IN_VALID, and at most one word is emitted per cycle.
//
// Ports:
//   USER_CLK, SYSTEM_RESET       - clock and synchronous active-high reset
//   DATA_IN/HEADER_IN/_VALID     - 64b payload, 2b sync header (01 data, 10 control), qualifier
//   DATA_OUT*                    - forwarded word with SOP/EOP/EOP_BYTES/CHANNEL/ERR tags
//   FLOW_CTRL_OUT/_RESET_CAL/_VALID - in-band flow-control field of the latest burst/idle word
//   PROTOCOL_ERR                 - one-cycle pulse per cycle containing any protocol violation
module rx_burst_interface #(
  parameter int unsigned BURST_MAX    = 32,
  parameter int unsigned NUM_CHANNELS = 256
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [63:0] DATA_IN,
  input  logic [1:0]  HEADER_IN,
  input  logic        DATA_IN_VALID,
  output logic [63:0] DATA_OUT,
  output logic        DATA_OUT_VALID,
  output logic        DATA_OUT_SOP,
  output logic        DATA_OUT_EOP,
  output logic [2:0]  DATA_OUT_EOP_BYTES,
  output logic [7:0]  DATA_OUT_CHANNEL,
  output logic        DATA_OUT_ERR,
  output logic [15:0] FLOW_CTRL_OUT,
  output logic        FLOW_CTRL_RESET_CAL,
  output logic        FLOW_CTRL_VALID,
  output logic        PROTOCOL_ERR
);

  // The counter saturates one above BURST_MAX, so the overflow pulse fires only once per burst.
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(BURST_MAX + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_t;

  // Packet-level state
  state_t           state_q, state_d;
  logic             sop_pend_q, sop_pend_d;
  logic [7:0]       pkt_ch_q, pkt_ch_d;
  logic             pkt_bad_q, pkt_bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One-word hold register: a word stays here until the next word tells us whether it was the last
  logic             hold_vld_q, hold_vld_d;
  logic [63:0]      hold_dat_q, hold_dat_d;
  logic             hold_sop_q, hold_sop_d;
  logic [7:0]       hold_ch_q, hold_ch_d;
  logic             hold_err_q, hold_err_d;

  // Registered outputs
  logic [63:0]      out_dat_q, out_dat_d;
  logic             out_vld_q, out_vld_d;
  logic             out_sop_q, out_sop_d;
  logic             out_eop_q, out_eop_d;
  logic [2:0]       out_bytes_q, out_bytes_d;
  logic [7:0]       out_ch_q, out_ch_d;
  logic             out_err_q, out_err_d;
  logic [15:0]      fc_q, fc_d;
  logic             rcal_q, rcal_d;
  logic             fc_vld_q, fc_vld_d;
  logic             perr_q, perr_d;

  // Control-word field decode
  logic       ctl_sop;
  logic [3:0] ctl_fmt;
  logic [7:0] ctl_ch;
  logic       ctl_ch_bad;

  assign ctl_sop    = DATA_IN[61];
  assign ctl_fmt    = DATA_IN[60:57];
  assign ctl_ch     = DATA_IN[39:32];
  assign ctl_ch_bad = ({24'd0, ctl_ch} >= NUM_CHANNELS);

  // Emission request for the held word, resolved below into the output registers
  logic       emit_en;
  logic       emit_eop;
  logic [2:0] emit_bytes;
  logic       emit_err;

  always_comb begin
    state_d     = state_q;
    sop_pend_d  = sop_pend_q;
    pkt_ch_d    = pkt_ch_q;
    pkt_bad_d   = pkt_bad_q;
    cnt_d       = cnt_q;
    hold_vld_d  = hold_vld_q;
    hold_dat_d  = hold_dat_q;
    hold_sop_d  = hold_sop_q;
    hold_ch_d   = hold_ch_q;
    hold_err_d  = hold_err_q;
    fc_d        = fc_q;
    rcal_d      = rcal_q;
    fc_vld_d    = 1'b0;
    perr_d      = 1'b0;
    emit_en     = 1'b0;
    emit_eop    = 1'b0;
    emit_bytes  = 3'd0;
    emit_err    = 1'b0;

    if (DATA_IN_VALID) begin
      unique case (HEADER_IN)
        2'b01: begin
          if (state_q == ST_PKT) begin
            // A new data word proves that the held word was not the last one
            if (hold_vld_q) begin
              emit_en = 1'b1;
            end
            hold_vld_d = 1'b1;
            hold_dat_d = DATA_IN;
            hold_sop_d = sop_pend_q;
            hold_ch_d  = pkt_ch_q;
            hold_err_d = pkt_bad_q;
            sop_pend_d = 1'b0;
            if (cnt_q == CNT_MAX) begin
              perr_d = 1'b1;
            end
            if (cnt_q != CNT_SAT) begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            perr_d = 1'b1;
          end
        end

        2'b10: begin
          // Other control-word types (framing words) pass without any effect
          if (DATA_IN[63:62] == 2'b11) begin
            fc_d     = DATA_IN[55:40];
            rcal_d   = DATA_IN[56];
            fc_vld_d = 1'b1;
            cnt_d    = '0;

            // EOP handling comes first; SOP may then open the next packet in the same word
            if (ctl_fmt != 4'b0000) begin
              if ((state_q == ST_PKT) && hold_vld_q) begin
                emit_en  = 1'b1;
                emit_eop = 1'b1;
                if (ctl_fmt[3]) begin
                  emit_bytes = ctl_fmt[2:0];
                end else begin
                  emit_err = 1'b1;
                  // Only 0001 is a legal error-EOP. Reserved codes also close the packet as errored
                  if (ctl_fmt != 4'b0001) begin
                    perr_d = 1'b1;
                  end
                end
              end else begin
                perr_d = 1'b1;
              end
              state_d    = ST_IDLE;
              hold_vld_d = 1'b0;
              sop_pend_d = 1'b0;
            end else if (hold_vld_q) begin
              // The burst boundary releases the held word. If a new SOP arrives while this packet is
              // still open, this is the abandoned packet's last word, so close it as errored
              emit_en    = 1'b1;
              hold_vld_d = 1'b0;
              if (ctl_sop) begin
                emit_eop = 1'b1;
                emit_err = 1'b1;
              end
            end

            if (ctl_sop) begin
              if (state_d == ST_PKT) begin
                perr_d = 1'b1;
              end
              if (ctl_ch_bad) begin
                perr_d = 1'b1;
              end
              state_d    = ST_PKT;
              sop_pend_d = 1'b1;
              pkt_ch_d   = ctl_ch;
              pkt_bad_d  = ctl_ch_bad;
              hold_vld_d = 1'b0;
            end
          end
        end

        default: begin
          perr_d = 1'b1;
        end
      endcase
    end

    // The output word always comes from the old hold contents. Output fields are zero when no word is emitted
    out_vld_d   = emit_en;
    out_dat_d   = emit_en ? hold_dat_q : 64'd0;
    out_sop_d   = emit_en & hold_sop_q;
    out_eop_d   = emit_en & emit_eop;
    out_bytes_d = emit_en ? emit_bytes : 3'd0;
    out_ch_d    = emit_en ? hold_ch_q : 8'd0;
    out_err_d   = emit_en & (hold_err_q | emit_err);
  end

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      state_q     <= ST_IDLE;
      sop_pend_q  <= 1'b0;
      pkt_ch_q    <= 8'd0;
      pkt_bad_q   <= 1'b0;
      cnt_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_dat_q  <= 64'd0;
      hold_sop_q  <= 1'b0;
      hold_ch_q   <= 8'd0;
      hold_err_q  <= 1'b0;
      out_dat_q   <= 64'd0;
      out_vld_q   <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_bytes_q <= 3'd0;
      out_ch_q    <= 8'd0;
      out_err_q   <= 1'b0;
      fc_q        <= 16'd0;
      rcal_q      <= 1'b0;
      fc_vld_q    <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sop_pend_q  <= sop_pend_d;
      pkt_ch_q    <= pkt_ch_d;
      pkt_bad_q   <= pkt_bad_d;
      cnt_q       <= cnt_d;
      hold_vld_q  <= hold_vld_d;
      hold_dat_q  <= hold_dat_d;
      hold_sop_q  <= hold_sop_d;
      hold_ch_q   <= hold_ch_d;
      hold_err_q  <= hold_err_d;
      out_dat_q   <= out_dat_d;
      out_vld_q   <= out_vld_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_bytes_q <= out_bytes_d;
      out_ch_q    <= out_ch_d;
      out_err_q   <= out_err_d;
      fc_q        <= fc_d;
      rcal_q      <= rcal_d;
      fc_vld_q    <= fc_vld_d;
      perr_q      <= perr_d;
    end
  end

  assign DATA_OUT            = out_dat_q;
  assign DATA_OUT_VALID      = out_vld_q;
  assign DATA_OUT_SOP        = out_sop_q;
  assign DATA_OUT_EOP        = out_eop_q;
  assign DATA_OUT_EOP_BYTES  = out_bytes_q;
  assign DATA_OUT_CHANNEL    = out_ch_q;
  assign DATA_OUT_ERR        = out_err_q;
  assign FLOW_CTRL_OUT       = fc_q;
  assign FLOW_CTRL_RESET_CAL = rcal_q;
  assign FLOW_CTRL_VALID     = fc_vld_q;
  assign PROTOCOL_ERR        = perr_q;

endmodule

// File: tb/tb_rx_burst_interface.sv
// Purpose : Directed self-checking bench for rx_burst_interface (BURST_MAX=4, NUM_CHANNELS=16).
// Latency : inputs are applied, one clock edge passes, and outputs are read #1 later.
// Backpress: none; every step drives exactly one input word or idle cycle.
module tb_rx_burst_interface;

  logic        USER_CLK;
  logic        SYSTEM_RESET;
  logic [63:0] DATA_IN;
  logic [1:0]  HEADER_IN;
  logic        DATA_IN_VALID;
  logic [63:0] DATA_OUT;
  logic        DATA_OUT_VALID;
  logic        DATA_OUT_SOP;
  logic        DATA_OUT_EOP;
  logic [2:0]  DATA_OUT_EOP_BYTES;
  logic [7:0]  DATA_OUT_CHANNEL;
  logic        DATA_OUT_ERR;
  logic [15:0] FLOW_CTRL_OUT;
  logic        FLOW_CTRL_RESET_CAL;
  logic        FLOW_CTRL_VALID;
  logic        PROTOCOL_ERR;

  int tests;
  int fails;

  rx_burst_interface #(
    .BURST_MAX   (4),
    .NUM_CHANNELS(16)
  ) dut (
    .USER_CLK           (USER_CLK),
    .SYSTEM_RESET       (SYSTEM_RESET),
    .DATA_IN            (DATA_IN),
    .HEADER_IN          (HEADER_IN),
    .DATA_IN_VALID      (DATA_IN_VALID),
    .DATA_OUT           (DATA_OUT),
    .DATA_OUT_VALID     (DATA_OUT_VALID),
    .DATA_OUT_SOP       (DATA_OUT_SOP),
    .DATA_OUT_EOP       (DATA_OUT_EOP),
    .DATA_OUT_EOP_BYTES (DATA_OUT_EOP_BYTES),
    .DATA_OUT_CHANNEL   (DATA_OUT_CHANNEL),
    .DATA_OUT_ERR       (DATA_OUT_ERR),
    .FLOW_CTRL_OUT      (FLOW_CTRL_OUT),
    .FLOW_CTRL_RESET_CAL(FLOW_CTRL_RESET_CAL),
    .FLOW_CTRL_VALID    (FLOW_CTRL_VALID),
    .PROTOCOL_ERR       (PROTOCOL_ERR)
  );

  initial USER_CLK = 1'b0;
  always #5 USER_CLK = ~USER_CLK;

  // Burst/idle control word: {11, SOP, EOP_FMT, RESET_CAL, FC, CHANNEL, 32'h0}
  function automatic logic [63:0] ctrl(input logic sop, input logic [3:0] fmt, input logic rcal,
                                       input logic [15:0] fc, input logic [7:0] ch);
    return {2'b11, sop, fmt, rcal, fc, ch, 32'h0};
  endfunction

  task automatic send(input logic [1:0] hdr, input logic [63:0] dat);
    HEADER_IN     = hdr;
    DATA_IN       = dat;
    DATA_IN_VALID = 1'b1;
    @(posedge USER_CLK);
    #1;
    DATA_IN_VALID = 1'b0;
  endtask

  task automatic idle();
    DATA_IN_VALID = 1'b0;
    HEADER_IN     = 2'b00;
    DATA_IN       = 64'd0;
    @(posedge USER_CLK);
    #1;
  endtask

  // Compares the whole data-out tag set plus PROTOCOL_ERR in one shot
  task automatic check_out(input string tag, input logic vld, input logic sop, input logic eop,
                           input logic [2:0] by, input logic [7:0] ch, input logic err,
                           input logic [63:0] dat, input logic perr);
    logic [79:0] obs;
    logic [79:0] exp;
    obs = {DATA_OUT_VALID, DATA_OUT_SOP, DATA_OUT_EOP, DATA_OUT_EOP_BYTES, DATA_OUT_CHANNEL,
           DATA_OUT_ERR, PROTOCOL_ERR, DATA_OUT};
    exp = {vld, sop, eop, by, ch, err, perr, dat};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed {vld,sop,eop,bytes,ch,err,perr,data}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_fc(input string tag, input logic vld, input logic [15:0] fc, input logic rcal);
    logic [17:0] obs;
    logic [17:0] exp;
    obs = {FLOW_CTRL_VALID, FLOW_CTRL_RESET_CAL, FLOW_CTRL_OUT};
    exp = {vld, rcal, fc};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed {fc_vld,rcal,fc}=%h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    SYSTEM_RESET  = 1'b1;
    DATA_IN       = 64'd0;
    HEADER_IN     = 2'b00;
    DATA_IN_VALID = 1'b0;
    @(posedge USER_CLK);
    @(posedge USER_CLK);
    #1;
    check_out("reset_out", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 0);
    check_fc("reset_fc", 0, 16'h0000, 0);
    SYSTEM_RESET = 1'b0;

    // Basic packet on channel 5 with a partial last word
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h1234, 8'd5));
    check_out("sop5_ctrl", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 0);
    check_fc("sop5_fc", 1, 16'h1234, 0);
    send(2'b01, 64'hA000_0000_0000_000A);
    check_out("data_a_held", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 0);
    send(2'b01, 64'hB000_0000_0000_000B);
    check_out("emit_a_sop", 1, 1, 0, 3'd0, 8'd5, 0, 64'hA000_0000_0000_000A, 0);
    send(2'b10, ctrl(0, 4'b1011, 0, 16'h0000, 8'd0));
    check_out("emit_b_eop", 1, 0, 1, 3'd3, 8'd5, 0, 64'hB000_0000_0000_000B, 0);
    check_fc("eop_fc", 1, 16'h0000, 0);
    idle();
    check_out("idle_zero", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 0);
    check_fc("idle_fc_hold", 0, 16'h0000, 0);

    // One control word closes packet X and opens packet Y on channel 7
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h0000, 8'd2));
    send(2'b01, 64'h1111_0000_0000_0001);
    send(2'b01, 64'h1111_0000_0000_0002);
    check_out("x1_emit", 1, 1, 0, 3'd0, 8'd2, 0, 64'h1111_0000_0000_0001, 0);
    send(2'b10, ctrl(1, 4'b1000, 0, 16'h0000, 8'd7));
    check_out("x2_eop_full", 1, 0, 1, 3'd0, 8'd2, 0, 64'h1111_0000_0000_0002, 0);
    send(2'b01, 64'hC000_0000_0000_000C);
    check_out("c_held", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 0);
    send(2'b10, ctrl(0, 4'b1111, 0, 16'h0000, 8'd0));
    check_out("c_emit_sop7", 1, 1, 1, 3'd7, 8'd7, 0, 64'hC000_0000_0000_000C, 0);

    // Error EOP, then flow-control update with the reset-calendar bit set
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h0000, 8'd3));
    send(2'b01, 64'hD000_0000_0000_000D);
    send(2'b10, ctrl(0, 4'b0001, 1, 16'hA5A5, 8'd0));
    check_out("d_err_eop", 1, 1, 1, 3'd0, 8'd3, 1, 64'hD000_0000_0000_000D, 0);
    check_fc("fc_a5a5", 1, 16'hA5A5, 1);
    idle();
    check_fc("fc_a5a5_hold", 0, 16'hA5A5, 1);

    // Three separate violations while idle
    send(2'b01, 64'hDEAD_0000_0000_0001);
    check_out("data_in_idle", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 1);
    send(2'b10, ctrl(0, 4'b1000, 0, 16'h0000, 8'd0));
    check_out("eop_in_idle", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 1);
    send(2'b11, 64'hDEAD_0000_0000_0002);
    check_out("hdr_11", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 1);
    idle();
    check_out("perr_clears", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 0);

    // A framing word inside a packet must neither emit nor disturb state
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h0000, 8'd4));
    send(2'b01, 64'hE000_0000_0000_000E);
    send(2'b10, 64'h4000_0000_0000_0000);
    check_out("framing_ignored", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 0);
    check_fc("framing_no_fc", 0, 16'h0000, 0);
    send(2'b01, 64'hF000_0000_0000_000F);
    check_out("e_after_framing", 1, 1, 0, 3'd0, 8'd4, 0, 64'hE000_0000_0000_000E, 0);
    send(2'b10, ctrl(0, 4'b1010, 0, 16'h0000, 8'd0));
    check_out("f_eop2", 1, 0, 1, 3'd2, 8'd4, 0, 64'hF000_0000_0000_000F, 0);

    // Burst overflow: the 5th word exceeds BURST_MAX=4, and every word is still forwarded
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h0000, 8'd1));
    send(2'b01, 64'h0000_0000_0000_0051);
    send(2'b01, 64'h0000_0000_0000_0052);
    check_out("w1_emit", 1, 1, 0, 3'd0, 8'd1, 0, 64'h0000_0000_0000_0051, 0);
    send(2'b01, 64'h0000_0000_0000_0053);
    send(2'b01, 64'h0000_0000_0000_0054);
    check_out("w4_no_perr", 1, 0, 0, 3'd0, 8'd1, 0, 64'h0000_0000_0000_0053, 0);
    send(2'b01, 64'h0000_0000_0000_0055);
    check_out("w5_overflow", 1, 0, 0, 3'd0, 8'd1, 0, 64'h0000_0000_0000_0054, 1);
    send(2'b10, ctrl(0, 4'b1000, 0, 16'h0000, 8'd0));
    check_out("w5_eop", 1, 0, 1, 3'd0, 8'd1, 0, 64'h0000_0000_0000_0055, 0);

    // SOP while the packet is still open: the held word closes as errored and a new packet opens
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h0000, 8'd6));
    send(2'b01, 64'h6000_0000_0000_0006);
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h0000, 8'd8));
    check_out("sop_in_pkt", 1, 1, 1, 3'd0, 8'd6, 1, 64'h6000_0000_0000_0006, 1);
    send(2'b01, 64'h8000_0000_0000_0008);
    send(2'b10, ctrl(0, 4'b1000, 0, 16'h0000, 8'd0));
    check_out("reopen_ch8", 1, 1, 1, 3'd0, 8'd8, 0, 64'h8000_0000_0000_0008, 0);

    // A reserved EOP encoding is flagged and treated as an error EOP
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h0000, 8'd9));
    send(2'b01, 64'h9000_0000_0000_0009);
    send(2'b10, ctrl(0, 4'b0101, 0, 16'h0000, 8'd0));
    check_out("rsvd_eop", 1, 1, 1, 3'd0, 8'd9, 1, 64'h9000_0000_0000_0009, 1);

    // A burst boundary without EOP releases the held word. A later EOP with an empty hold is a violation
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h0000, 8'd10));
    send(2'b01, 64'h0A00_0000_0000_000A);
    send(2'b10, ctrl(0, 4'b0000, 0, 16'h0000, 8'd0));
    check_out("burst_boundary", 1, 1, 0, 3'd0, 8'd10, 0, 64'h0A00_0000_0000_000A, 0);
    send(2'b10, ctrl(0, 4'b1000, 0, 16'h0000, 8'd0));
    check_out("eop_hold_empty", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 1);
    send(2'b01, 64'h0A00_0000_0000_00AA);
    check_out("now_idle", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 1);

    // Channel 20 is out of range for NUM_CHANNELS=16
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h0000, 8'd20));
    check_out("bad_channel", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 1);
    send(2'b01, 64'h1400_0000_0000_0014);
    send(2'b10, ctrl(0, 4'b1001, 0, 16'h0000, 8'd0));
    check_out("bad_ch_word_err", 1, 1, 1, 3'd1, 8'd20, 1, 64'h1400_0000_0000_0014, 0);

    // Reset with a full hold register discards the held word, even with a valid input in that cycle
    send(2'b10, ctrl(1, 4'b0000, 0, 16'h5A5A, 8'd2));
    send(2'b01, 64'h2000_0000_0000_0001);
    send(2'b01, 64'h2000_0000_0000_0002);
    check_out("pre_reset_emit", 1, 1, 0, 3'd0, 8'd2, 0, 64'h2000_0000_0000_0001, 0);
    SYSTEM_RESET = 1'b1;
    send(2'b01, 64'h2000_0000_0000_0003);
    check_out("reset_dominates", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 0);
    check_fc("reset_clears_fc", 0, 16'h0000, 0);
    SYSTEM_RESET = 1'b0;
    send(2'b01, 64'h2000_0000_0000_0004);
    check_out("post_reset_idle", 0, 0, 0, 3'd0, 8'd0, 0, 64'd0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
